pingpong_frame_ctrl: RTL
========================

Name: pingpong_frame_ctrl

Overview:
Controller for the two-bank ping-pong frame store that sits in front of the bilateral filter. It registers the incoming pixel stream and generates the write enable, bank select and row/column address for the buffering bank. When a frame is complete it hands that bank to a read sequencer, which scans every pixel address of the bank for the window-generating memory. It tracks bank ownership and discards whole frames when no bank is free.

Parameters:
ROW_W, 7, row address width (frame height = 2^ROW_W)
COL_W, 7, column address width (frame width = 2^COL_W)
PIX_W, 10, pixel width
RD_LAT, 4, cycles from the last read address to the last window leaving the frame memory (drain time before bank release)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active-high
in_data  in  PIX_W  incoming pixel
in_valid  in  1  pixel qualifier, raster order, no back-pressure
wr_en  out  1  write strobe to the selected bank
wr_bank  out  1  bank being written
wr_row  out  ROW_W  write row
wr_col  out  COL_W  write column
wr_data  out  PIX_W  write pixel
rd_ready  in  1  downstream can accept a read address this cycle
rd_addr_valid  out  1  read address issued this cycle
rd_bank  out  1  bank being read
rd_row  out  ROW_W  read row
rd_col  out  COL_W  read column
rd_busy  out  1  read sequencer not IDLE
rd_frame_done  out  1  one-cycle pulse when the read bank is released
drop_pulse  out  1  one-cycle pulse at the end of each discarded frame
frames_dropped  out  16  saturating count of discarded frames

Behaviour:
- Reset (sys_rst=1 at a clock edge): all outputs 0, wr_cnt=0, wr_bank=0, full[1:0]=0, drop mode off, read FSM in IDLE, frames_dropped=0. Reset mid-frame or mid-scan abandons all work with no done or drop pulse.
- wr_cnt: ROW_W+COL_W bits, increments on every in_valid, including in drop mode, so frame alignment is kept. It wraps from all-ones to 0. The last pixel of a frame is in_valid with wr_cnt all-ones.
- Write path: registered, latency 1. The cycle after in_valid, wr_en = not drop mode, and wr_row/wr_col = wr_cnt[high]/wr_cnt[low], wr_data = in_data. wr_en=0 otherwise.
- End of a written frame: full[wr_bank] is set. If the other bank is free (not full and not reading, evaluated after any same-cycle release), wr_bank toggles for the next frame. Otherwise drop mode is entered.
- Drop mode: pixels are counted but not written. At each dropped-frame end, drop_pulse fires and frames_dropped increments (saturating at 0xFFFF). Drop mode exits only at a frame boundary, with wr_bank set to the free bank, if one is free at that point.
- Read FSM states:
  - IDLE: if a bank is full and not reading, set rd_bank to that bank and go to SCAN on the next cycle. At most one such bank can exist.
  - SCAN: rd_addr_valid=rd_ready, and the address advances only when rd_ready=1. rd_row/rd_col are held while rd_ready=0. The address starts at 0 and is issued in raster order. Issuing the all-ones address goes to DRAIN.
  - DRAIN: count RD_LAT cycles. On the last cycle, clear full[rd_bank], pulse rd_frame_done and return to IDLE.
- rd_busy=1 in SCAN and DRAIN. rd_bank is stable for the whole SCAN/DRAIN.
- Latency: a bank completing at cycle t (IDLE, no conflict) gives its first rd_addr_valid at t+2.
- Simultaneous events:
  - A bank release and a write-frame end in the same cycle: the released bank counts as free, so there is no drop.
  - A release and a drop-frame end in the same cycle: drop mode exits.
- Invariant: wr_bank never equals rd_bank while wr_en is asserted during rd_busy.

Test Plan:
Bench configuration: ROW_W=2, COL_W=2 (16-pixel frames), RD_LAT=3.
1. Reset: hold sys_rst for 3 cycles with in_valid toggling -> every output stays 0. After release the first pixel is written to bank 0, address (0,0).
2. One frame of 16 back-to-back pixels, values 0..15, rd_ready=1 -> wr_en for 16 cycles on bank 0, addresses 0..15, data 0..15. rd_addr_valid starts 2 cycles after the last in_valid, on bank 0, addresses 0..15. rd_frame_done comes 3 cycles after the last address. The next frame writes bank 1.
3. Back-pressure: rd_ready toggled 1,0,1,0... during SCAN -> 16 addresses issued with no skips or repeats, each held while rd_ready=0. Scan length is 31 cycles.
4. Overflow: rd_ready=0 and 3 frames sent -> frame 0 goes to bank 0 (SCAN stalled at address 0), frame 1 goes to bank 1, frame 2 is dropped with wr_en=0, drop_pulse once and frames_dropped=1. Then rd_ready=1: bank 0 is released and bank 1 is read, and frame 3 is written to bank 0.
5. Simultaneous: align the bank-0 release in DRAIN with the last pixel of the frame in bank 1 -> no drop, and the next frame writes bank 0.
6. Reset mid-SCAN at address 7 -> no rd_frame_done, rd_busy=0. The next frame writes bank 0 and is read from address 0.

Source files
------------

// File: rtl/pingpong_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_frame_ctrl
//
// Two-bank ping-pong frame store controller placed in front of the bilateral
// filter. The incoming raster pixel stream is registered and turned into
// write strobes and row/column addresses for the bank currently being filled.
// Each completed bank is handed to a read sequencer. The sequencer scans every
// pixel address of that bank in raster order for the window-generating memory.
// It then waits a fixed drain time before releasing the bank. When no bank is
// free at a frame boundary, whole frames are discarded and counted.
//
// Parameters
//   ROW_W   row address width   (frame height = 2**ROW_W)
//   COL_W   column address width (frame width = 2**COL_W)
//   PIX_W   pixel width
//   RD_LAT  cycles from the last read address until the last window leaves
//           the frame memory (drain time before the bank is released)
//
// Ports
//   sys_clk        clock
//   sys_rst        synchronous reset, active-high
//   in_data        incoming pixel
//   in_valid       pixel qualifier, raster order, no back-pressure
//   wr_en          write strobe to the selected bank (one cycle after in_valid)
//   wr_bank        bank being written
//   wr_row/wr_col  write address
//   wr_data        write pixel
//   rd_ready       downstream can accept a read address this cycle
//   rd_addr_valid  read address issued this cycle
//   rd_bank        bank being read (stable for the whole scan and drain)
//   rd_row/rd_col  read address
//   rd_busy        read sequencer is scanning or draining
//   rd_frame_done  one-cycle pulse when the read bank is released
//   drop_pulse     one-cycle pulse at the end of each discarded frame
//   frames_dropped saturating count of discarded frames
// -----------------------------------------------------------------------------
module pingpong_frame_ctrl #(
   parameter int ROW_W  = 7,
   parameter int COL_W  = 7,
   parameter int PIX_W  = 10,
   parameter int RD_LAT = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [PIX_W-1:0] in_data,
   input  logic             in_valid,
   output logic             wr_en,
   output logic             wr_bank,
   output logic [ROW_W-1:0] wr_row,
   output logic [COL_W-1:0] wr_col,
   output logic [PIX_W-1:0] wr_data,
   input  logic             rd_ready,
   output logic             rd_addr_valid,
   output logic             rd_bank,
   output logic [ROW_W-1:0] rd_row,
   output logic [COL_W-1:0] rd_col,
   output logic             rd_busy,
   output logic             rd_frame_done,
   output logic             drop_pulse,
   output logic [15:0]      frames_dropped
);

   localparam int ADDR_W = ROW_W + COL_W;
   localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_SCAN  = 2'd1,
      RD_DRAIN = 2'd2
   } rd_state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   // Write side
   logic [ADDR_W-1:0] wr_cnt_reg;
   logic              cur_bank_reg;      // bank owned by the frame being received
   logic              cur_bank_next;
   logic              drop_reg;
   logic              drop_next;
   logic [1:0]        full_reg;
   logic [1:0]        full_next;

   // Registered write port
   logic              wr_en_reg;
   logic              wr_bank_reg;
   logic [ROW_W-1:0]  wr_row_reg;
   logic [COL_W-1:0]  wr_col_reg;
   logic [PIX_W-1:0]  wr_data_reg;

   // Drop reporting
   logic              drop_pulse_reg;
   logic              drop_pulse_next;
   logic [15:0]       frames_dropped_reg;
   logic [15:0]       frames_dropped_next;

   // Read sequencer
   rd_state_t         rd_state_reg;
   rd_state_t         rd_state_next;
   logic              rd_bank_reg;
   logic [ADDR_W-1:0] rd_addr_reg;
   logic [LAT_W-1:0]  drain_cnt_reg;
   logic              drain_last;

   // ---------------------------------------------------------------------------
   // Bank ownership
   // ---------------------------------------------------------------------------
   // A bank is free when it holds no unread frame and the sequencer is not
   // using it. A release happening this cycle already counts as free, so a
   // frame end that coincides with a release never causes a drop.
   logic [1:0] rel_mask;
   logic [1:0] reading_mask;
   logic [1:0] free_mask;
   logic       free_any;
   logic       free_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         assign rel_mask[gi]     = rd_frame_done && (rd_bank_reg == 1'(gi));
         assign reading_mask[gi] = rd_busy && !rd_frame_done && (rd_bank_reg == 1'(gi));
         assign free_mask[gi]    = !(full_reg[gi] && !rel_mask[gi]) && !reading_mask[gi];
      end
   endgenerate

   assign free_any = |free_mask;
   // In drop mode both banks are occupied, and at most one is released per
   // cycle, so at most one bank can be free here.
   assign free_sel = !free_mask[0];

   // ---------------------------------------------------------------------------
   // Frame tracking and drop decisions
   // ---------------------------------------------------------------------------
   logic cnt_last;
   logic cnt_first;
   logic drop_exit_idle;
   logic drop_eff;
   logic bank_eff;
   logic other_bank;
   logic wr_frame_end;
   logic drop_frame_end;

   assign cnt_last  = &wr_cnt_reg;
   assign cnt_first = (wr_cnt_reg == '0);

   // Between frames (counter at zero), a drop mode that finds a free bank is
   // left immediately. A first pixel that arrives in that same cycle is
   // therefore already written into the freed bank.
   assign drop_exit_idle = drop_reg && cnt_first && free_any;
   assign drop_eff       = drop_reg && !drop_exit_idle;
   assign bank_eff       = drop_exit_idle ? free_sel : cur_bank_reg;
   assign other_bank     = ~bank_eff;

   assign wr_frame_end   = in_valid && cnt_last && !drop_eff;
   assign drop_frame_end = in_valid && cnt_last && drop_eff;

   always_comb begin
      cur_bank_next       = bank_eff;
      drop_next           = drop_eff;
      full_next           = full_reg & ~rel_mask;
      drop_pulse_next     = 1'b0;
      frames_dropped_next = frames_dropped_reg;

      if (wr_frame_end) begin
         full_next[bank_eff] = 1'b1;
         if (free_mask[other_bank]) begin
            cur_bank_next = other_bank;
         end else begin
            drop_next = 1'b1;
         end
      end

      if (drop_frame_end) begin
         drop_pulse_next = 1'b1;
         if (frames_dropped_reg != 16'hFFFF) begin
            frames_dropped_next = frames_dropped_reg + 16'd1;
         end
         if (free_any) begin
            drop_next     = 1'b0;
            cur_bank_next = free_sel;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_cnt_reg         <= '0;
         cur_bank_reg       <= 1'b0;
         drop_reg           <= 1'b0;
         full_reg           <= 2'b00;
         drop_pulse_reg     <= 1'b0;
         frames_dropped_reg <= 16'd0;
      end else begin
         // The counter keeps running in drop mode so frame alignment is kept.
         if (in_valid) begin
            wr_cnt_reg <= wr_cnt_reg + ADDR_W'(1);
         end
         cur_bank_reg       <= cur_bank_next;
         drop_reg           <= drop_next;
         full_reg           <= full_next;
         drop_pulse_reg     <= drop_pulse_next;
         frames_dropped_reg <= frames_dropped_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered write port (latency 1 from in_valid)
   // ---------------------------------------------------------------------------
   // The bank is captured together with the address. The bank register itself
   // already points at the next frame's bank when the last pixel is written.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_en_reg   <= 1'b0;
         wr_bank_reg <= 1'b0;
         wr_row_reg  <= '0;
         wr_col_reg  <= '0;
         wr_data_reg <= '0;
      end else begin
         wr_en_reg <= in_valid && !drop_eff;
         if (in_valid) begin
            wr_bank_reg <= bank_eff;
            wr_row_reg  <= wr_cnt_reg[ADDR_W-1:COL_W];
            wr_col_reg  <= wr_cnt_reg[COL_W-1:0];
            wr_data_reg <= in_data;
         end
      end
   end

   assign wr_en          = wr_en_reg;
   assign wr_bank        = wr_bank_reg;
   assign wr_row         = wr_row_reg;
   assign wr_col         = wr_col_reg;
   assign wr_data        = wr_data_reg;
   assign drop_pulse     = drop_pulse_reg;
   assign frames_dropped = frames_dropped_reg;

   // ---------------------------------------------------------------------------
   // Read sequencer FSM
   // ---------------------------------------------------------------------------
   assign drain_last = (drain_cnt_reg == LAT_W'(RD_LAT - 1));

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rd_state_reg <= RD_IDLE;
      end else begin
         rd_state_reg <= rd_state_next;
      end
   end

   // Next-state logic. In IDLE, no bank is being read, so any full bank is a
   // candidate, and only one bank can be full in that state.
   always_comb begin
      rd_state_next = rd_state_reg;
      case (rd_state_reg)
         RD_IDLE: begin
            if (|full_reg) begin
               rd_state_next = RD_SCAN;
            end
         end
         RD_SCAN: begin
            if (rd_ready && (&rd_addr_reg)) begin
               rd_state_next = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (drain_last) begin
               rd_state_next = RD_IDLE;
            end
         end
         default: rd_state_next = RD_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      rd_addr_valid = 1'b0;
      rd_busy       = 1'b0;
      rd_frame_done = 1'b0;
      case (rd_state_reg)
         RD_SCAN: begin
            rd_addr_valid = rd_ready;
            rd_busy       = 1'b1;
         end
         RD_DRAIN: begin
            rd_busy       = 1'b1;
            rd_frame_done = drain_last;
         end
         default: begin
            rd_addr_valid = 1'b0;
         end
      endcase
   end

   // Sequencer datapath: bank latch, scan address and drain counter
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rd_bank_reg   <= 1'b0;
         rd_addr_reg   <= '0;
         drain_cnt_reg <= '0;
      end else begin
         case (rd_state_reg)
            RD_IDLE: begin
               rd_addr_reg   <= '0;
               drain_cnt_reg <= '0;
               if (|full_reg) begin
                  rd_bank_reg <= full_reg[1];
               end
            end
            RD_SCAN: begin
               // Address holds while the consumer stalls
               if (rd_ready) begin
                  rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
               end
            end
            RD_DRAIN: begin
               drain_cnt_reg <= drain_cnt_reg + LAT_W'(1);
            end
            default: begin
               drain_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign rd_bank = rd_bank_reg;
   assign rd_row  = rd_addr_reg[ADDR_W-1:COL_W];
   assign rd_col  = rd_addr_reg[COL_W-1:0];

endmodule
